lfsr_seq_checker: RTL and testbench



---
 rtl/lfsr_seq_checker.sv | 143 ++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 14-bit Sierpinski LFSR: self-synchronises, locks, counts mismatches.
// Optional macro LFSR_SEQ_CHECKER_PERIOD_EN adds a measured sequence period output.
module lfsr_seq_checker #(
    parameter int LOCK_COUNT = 8,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [13:0]      in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
    output logic [13:0]      period,
    output logic             period_valid,
`endif
    output logic             zero_seen
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_N = 8'(LOSS_COUNT);

    function automatic logic [13:0] lfsr_next(input logic [13:0] x);
        return {x[12:0], x[13] ^ x[12] ^ x[11] ^ x[1]};
    endfunction

    state_t      state;
    logic [13:0] ref_q;
    logic [7:0]  run;
    logic [13:0] pred;
    logic [7:0]  run_inc;
    logic        match;
    logic        miss;
    logic        lose;

    assign pred    = lfsr_next(ref_q);
    assign run_inc = run + 8'd1;
    assign match   = (in_data == pred);
    assign miss    = in_valid && (state == LOCKED) && !match;
    assign lose    = miss && (run_inc == LOSS_N);

    // NOTE: every register here is updated with <= so all reads see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            ref_q     <= '0;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            zero_seen <= 1'b0;
        end else begin
            err_pulse <= miss;
            if (clr_cnt)
                err_count <= miss ? CNT_W'(1) : '0;
            else if (miss && (err_count != '1))
                err_count <= err_count + CNT_W'(1);

            if (in_valid) begin
                if (in_data == '0)
                    zero_seen <= 1'b1;
                case (state)
                    HUNT: begin
                        if (in_data != '0) begin
                            ref_q <= in_data;
                            run   <= '0;
                            state <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (in_data == '0) begin
                            state <= HUNT;
                            run   <= '0;
                        end else if (match) begin
                            ref_q <= in_data;
                            if (run_inc == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                run    <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            ref_q <= in_data;
                            run   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            ref_q <= in_data;
                            run   <= '0;
                        end else begin
                            // Flywheel: keep predicting from our own sequence, never from bad data.
                            ref_q <= pred;
                            if (lose) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                                run    <= '0;
                            end else begin
                                run <= run_inc;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        run    <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
    logic [13:0] per_cnt;

    // The count restarts at 1 on each 0x0001, so the value held at the next 0x0001 is the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else if (lose) begin
            per_cnt      <= '0;
            period_valid <= 1'b0;
        end else if (in_valid && (state == LOCKED)) begin
            if (in_data == 14'h0001) begin
                period       <= per_cnt;
                period_valid <= 1'b1;
                per_cnt      <= 14'd1;
            end else begin
                per_cnt <= per_cnt + 14'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: two parameterisations share randomized stimulus and a behavioural model.
// Define LFSR_SEQ_CHECKER_PERIOD_EN to also exercise the period measurement.
module tb_lfsr_seq_checker;

    localparam int MODE_HUNT = 0, MODE_VERIFY = 1, MODE_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [13:0] in_data = '0;
    logic        clr_cnt = 1'b0;

    logic        locked1, err_pulse1, zero_seen1;
    logic [15:0] err_count1;
    logic        locked2, err_pulse2, zero_seen2;
    logic [3:0]  err_count2;
`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
    logic [13:0] period1, period2;
    logic        period_valid1, period_valid2;
`endif

    always #5 clk = ~clk;

    lfsr_seq_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked1), .err_pulse(err_pulse1), .err_count(err_count1),
`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
        .period(period1), .period_valid(period_valid1),
`endif
        .zero_seen(zero_seen1)
    );

    lfsr_seq_checker #(.LOCK_COUNT(3), .LOSS_COUNT(6), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2),
`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
        .period(period2), .period_valid(period_valid2),
`endif
        .zero_seen(zero_seen2)
    );

    typedef struct packed {
        int          mode;
        logic [13:0] rf;
        int          run;
        bit          lk;
        bit          ep;
        int          ec;
        bit          zs;
    } mdl_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    mdl_t m1, m2;
    logic [13:0] g;

    function automatic logic [13:0] f(input logic [13:0] x);
        return {x[12:0], x[13] ^ x[12] ^ x[11] ^ x[1]};
    endfunction

    // Behavioural rules: what the checker must believe after one clock with these inputs.
    function automatic mdl_t m_step(input mdl_t s, input bit r, input bit v, input logic [13:0] d,
                                    input bit c, input int lock_n, input int loss_n, input int cmax);
        mdl_t n;
        bit   err;
        logic [13:0] p;
        n   = s;
        err = 1'b0;
        if (r) begin
            n = '0;
            n.mode = MODE_HUNT;
            return n;
        end
        p = f(s.rf);
        if (v) begin
            if (d == 14'h0) n.zs = 1'b1;
            if (s.mode == MODE_HUNT) begin
                if (d != 14'h0) begin n.rf = d; n.run = 0; n.mode = MODE_VERIFY; end
            end else if (s.mode == MODE_VERIFY) begin
                if (d == 14'h0) begin n.mode = MODE_HUNT; n.run = 0; end
                else if (d == p) begin
                    n.rf = d; n.run = s.run + 1;
                    if (n.run == lock_n) begin n.mode = MODE_LOCKED; n.run = 0; end
                end else begin n.rf = d; n.run = 0; end
            end else begin
                if (d == p) begin n.rf = d; n.run = 0; end
                else begin
                    err = 1'b1; n.rf = p; n.run = s.run + 1;
                    if (n.run == loss_n) begin n.mode = MODE_HUNT; n.run = 0; end
                end
            end
        end
        if (c) n.ec = err ? 1 : 0;
        else if (err && s.ec < cmax) n.ec = s.ec + 1;
        n.ep = err;
        n.lk = (n.mode == MODE_LOCKED);
        return n;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m1 = m_step(m1, rst, in_valid, in_data, clr_cnt, 8, 4, 16'hFFFF);
        m2 = m_step(m2, rst, in_valid, in_data, clr_cnt, 3, 6, 15);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked", 32'(locked1), 32'(m1.lk));
            check("err_pulse", 32'(err_pulse1), 32'(m1.ep));
            check("err_count", 32'(err_count1), m1.ec);
            check("zero_seen", 32'(zero_seen1), 32'(m1.zs));
            check("small.locked", 32'(locked2), 32'(m2.lk));
            check("small.err_pulse", 32'(err_pulse2), 32'(m2.ep));
            check("small.err_count", 32'(err_count2), m2.ec);
            check("small.zero_seen", 32'(zero_seen2), 32'(m2.zs));
        end
    end

    task automatic drive(input bit r, input bit v, input logic [13:0] d, input bit c);
        rst = r; in_valid = v; in_data = d; clr_cnt = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic good(input bit c);
        drive(1'b0, 1'b1, g, c);
        g = f(g);
    endtask

    task automatic bad(input logic [13:0] d, input bit c);
        drive(1'b0, 1'b1, d, c);
        g = f(g);
    endtask

    initial begin
        int burst;
        drive(1'b1, 1'b0, 14'h0, 1'b0);
        drive(1'b1, 1'b0, 14'h0, 1'b0);
        chk_en = 1'b1;
        check("rst.locked", 32'(locked1), 0);
        check("rst.err_count", 32'(err_count1), 0);
        check("rst.zero_seen", 32'(zero_seen1), 0);

        // Seed plus eight matches: lock appears after the ninth word.
        g = 14'h0001;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) check("seq.word3", 32'(g), 32'h000A);
            good(1'b0);
            if (i == 7) check("lock.before", 32'(locked1), 0);
        end
        check("lock.after", 32'(locked1), 1);
        check("lock.err_count", 32'(err_count1), 0);

        bad(14'h3FFF, 1'b0);
        check("single.pulse", 32'(err_pulse1), 1);
        check("single.count", 32'(err_count1), 1);
        check("single.locked", 32'(locked1), 1);
        good(1'b0);
        check("flywheel.pulse", 32'(err_pulse1), 0);
        check("flywheel.count", 32'(err_count1), 1);

        good(1'b1);
        check("clr.count", 32'(err_count1), 0);
        for (int i = 0; i < 4; i++) begin
            bad(14'h3FFF, 1'b0);
            if (i == 2) check("loss.before", 32'(locked1), 1);
        end
        check("loss.count", 32'(err_count1), 4);
        check("loss.locked", 32'(locked1), 0);
        for (int i = 0; i < 9; i++) begin
            good(1'b0);
            if (i == 7) check("relock.before", 32'(locked1), 0);
        end
        check("relock.after", 32'(locked1), 1);

        // Alternate misses and matches so lock holds while the small counter saturates.
        for (int i = 0; i < 20; i++) begin
            bad(~g, 1'b0);
            good(1'b0);
        end
        check("sat.small", 32'(err_count2), 15);
        check("sat.locked", 32'(locked1), 1);
        bad(~g, 1'b1);
        check("clr_err.count", 32'(err_count1), 1);
        check("clr_err.small", 32'(err_count2), 1);

        drive(1'b1, 1'b0, 14'h0, 1'b0);
        drive(1'b0, 1'b1, 14'h0, 1'b0);
        check("zero.seen", 32'(zero_seen1), 1);
        check("zero.locked", 32'(locked1), 0);
        drive(1'b1, 1'b0, 14'h0, 1'b0);
        check("zero.cleared", 32'(zero_seen1), 0);

        g = 14'h0001;
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r, v, c;
            logic [13:0] d;
            r = ($urandom_range(0, 999) == 0);
            v = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 199) == 0) g = 14'($urandom_range(1, 16383));
            d = g;
            if (v) begin
                if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(1, 7);
                if (burst > 0) begin
                    d = ($urandom_range(0, 9) == 0) ? 14'h0 : 14'($urandom);
                    burst--;
                end
                g = f(g);
            end
            drive(r, v, d, c);
        end

`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
        begin
            int          len;
            logic [13:0] x;
            len = 1;
            x   = f(14'h0001);
            while (x != 14'h0001 && len < 20000) begin
                x = f(x);
                len++;
            end
            drive(1'b1, 1'b0, 14'h0, 1'b0);
            g = 14'h0001;
            for (int i = 0; i <= 2 * len; i++) good(1'b0);
            check("period.value", 32'(period1), len);
            check("period.valid", 32'(period_valid1), 1);
        end
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
